icache_assoc: RTL and testbench

ICACHE_ASSOC -- requirements
Module: icache_assoc

---
 rtl/icache_assoc_pkg.sv | 21 ++
 rtl/icache_way.sv | 70 +++++++
 rtl/icache_assoc.sv | 200 ++++++++++++++++++++
 tb/tb_icache_assoc.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_assoc_pkg.sv
// -----------------------------------------------------------------------------
// icache_assoc_pkg
// Definitions shared by the set-associative instruction cache: the address and
// data bus widths, the encoding of a valid line, and a helper that sizes the
// per-set round-robin pointer.
// -----------------------------------------------------------------------------
package icache_assoc_pkg;

    localparam int ADDR_BUS = 32;
    localparam int DATA_BUS = 32;

    localparam logic VALID   = 1'b1;
    localparam logic INVALID = 1'b0;

    // A direct-mapped cache still carries a 1-bit pointer so that no vector
    // ever ends up zero-width; that bit simply never changes.
    function automatic int ptr_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/icache_way.sv
// -----------------------------------------------------------------------------
// icache_way
// Storage for one way of the instruction cache: per-set data word, tag and
// valid bit.
//
// Ports
//   clk, rst        clock and asynchronous active-high reset (valid bits only)
//   rd_idx_i        set index of the current lookup
//   rd_tag_i        tag of the current lookup
//   rd_hit_o        set is valid in this way and its tag matches
//   rd_data_o       data word stored at rd_idx_i
//   we_i            write data/tag at wr_idx_i and mark the entry valid
//   inv_all_i       clear every valid bit of this way (takes priority)
//   wr_idx_i        set index for writes and for wr_valid_o
//   wr_tag_i        tag to write
//   wr_data_i       data word to write
//   wr_valid_o      valid bit of the entry at wr_idx_i (victim selection)
// -----------------------------------------------------------------------------
module icache_way
    import icache_assoc_pkg::*;
#(
    parameter  int SETS  = 64,
    parameter  int TAG_W = 9,
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    rd_idx_i,
    input  logic [TAG_W-1:0]    rd_tag_i,
    output logic                rd_hit_o,
    output logic [DATA_BUS-1:0] rd_data_o,
    input  logic                we_i,
    input  logic                inv_all_i,
    input  logic [IDX_W-1:0]    wr_idx_i,
    input  logic [TAG_W-1:0]    wr_tag_i,
    input  logic [DATA_BUS-1:0] wr_data_i,
    output logic                wr_valid_o
);

    logic [SETS-1:0]     valid_q;
    logic [TAG_W-1:0]    tag_q  [SETS];
    logic [DATA_BUS-1:0] data_q [SETS];

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (inv_all_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= VALID;
        end
    end

    // NOTE: the tag and data arrays carry no reset; a stale entry is harmless
    // because it is never reported without its valid bit, and leaving the
    // reset off lets the arrays map onto plain RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_hit_o   = (valid_q[rd_idx_i] == VALID) && (tag_q[rd_idx_i] == rd_tag_i);
    assign rd_data_o  = data_q[rd_idx_i];
    assign wr_valid_o = valid_q[wr_idx_i];

endmodule

// File: rtl/icache_assoc.sv
// -----------------------------------------------------------------------------
// icache_assoc
// Blocking, set-associative instruction cache with one outstanding refill.
// Lookup is combinational; a miss moves the FSM to REFILL, which requests the
// word-aligned line address from memory and installs the returned word into
// the victim way (lowest invalid way, else the set's round-robin pointer).
// The returned word is forwarded to the fetch stage in the same cycle when the
// fetch address still matches the refill.
//
// Ports
//   clk, rst        clock and asynchronous active-high reset
//   rdy             global enable; 0 freezes all state
//   fetchEn, Addr   fetch request and byte address (bits [1:0] ignored)
//   flush           invalidate all lines; aborts an in-flight refill
//   memValid        memory returns memInst for the outstanding request
//   memInst         returned instruction word
//   hit, foundInst  lookup result for Addr this cycle
//   memfetchEn      refill request to memory
//   memfetchAddr    word-aligned refill address
// -----------------------------------------------------------------------------
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int SETS  = 64,
    parameter int TAG_W = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                fetchEn,
    input  logic [ADDR_BUS-1:0] Addr,
    input  logic                flush,
    input  logic                memValid,
    input  logic [DATA_BUS-1:0] memInst,
    output logic                hit,
    output logic [DATA_BUS-1:0] foundInst,
    output logic                memfetchEn,
    output logic [ADDR_BUS-1:0] memfetchAddr
);

    localparam int IDX_W = $clog2(SETS);
    localparam int PTR_W = ptr_width(WAYS);

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_BUS-1:0] addr_q, addr_d;
    logic                abort_q, abort_d;
    logic [PTR_W-1:0]    rr_ptr_q [SETS];

    // Fetch stage lookup fields and the fields of the latched refill address.
    logic [IDX_W-1:0] idx, l_idx;
    logic [TAG_W-1:0] tag, l_tag;

    assign idx   = Addr[IDX_W+1:2];
    assign tag   = Addr[IDX_W+TAG_W+1:IDX_W+2];
    assign l_idx = addr_q[IDX_W+1:2];
    assign l_tag = addr_q[IDX_W+TAG_W+1:IDX_W+2];

    // Byte offset within a word plays no part in instruction fetch.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^Addr[1:0];

    logic [WAYS-1:0]     way_hit;
    logic [DATA_BUS-1:0] way_data [WAYS];
    logic [WAYS-1:0]     way_valid_l;
    logic [WAYS-1:0]     way_we;
    logic                flush_en;

    assign flush_en = rdy && flush;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .SETS  (SETS),
            .TAG_W (TAG_W)
        ) u_way (
            .clk        (clk),
            .rst        (rst),
            .rd_idx_i   (idx),
            .rd_tag_i   (tag),
            .rd_hit_o   (way_hit[w]),
            .rd_data_o  (way_data[w]),
            .we_i       (way_we[w]),
            .inv_all_i  (flush_en),
            .wr_idx_i   (l_idx),
            .wr_tag_i   (l_tag),
            .wr_data_i  (memInst),
            .wr_valid_o (way_valid_l[w])
        );
    end

    // Hit mux: at most one way can match, since a line is only installed
    // after a lookup of it has missed.
    logic                lookup_hit;
    logic [DATA_BUS-1:0] lookup_data;

    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) begin
                lookup_hit  = 1'b1;
                lookup_data = way_data[w];
            end
        end
    end

    // Victim: scanning downward leaves the lowest-numbered invalid way.
    logic [PTR_W-1:0] victim;
    logic             all_valid;
    logic [PTR_W-1:0] ptr_next;

    always_comb begin
        all_valid = &way_valid_l;
        victim    = rr_ptr_q[l_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_valid_l[w] != VALID) begin
                victim = PTR_W'(w);
            end
        end
        ptr_next = (rr_ptr_q[l_idx] == PTR_W'(WAYS - 1)) ? '0 : rr_ptr_q[l_idx] + 1'b1;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            abort_q <= abort_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        abort_d = abort_q;
        if (rdy) begin
            unique case (state_q)
                IDLE: begin
                    if (fetchEn && !lookup_hit && !flush) begin
                        state_d = REFILL;
                        addr_d  = {Addr[ADDR_BUS-1:2], 2'b00};
                        abort_d = 1'b0;
                    end
                end
                REFILL: begin
                    // memValid always closes the refill; flush only decides
                    // whether the word is installed.
                    if (memValid) begin
                        state_d = IDLE;
                        abort_d = 1'b0;
                    end else if (flush) begin
                        abort_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    logic install;
    logic bypass;

    always_comb begin
        memfetchEn   = (state_q == REFILL);
        memfetchAddr = addr_q;
        install      = (state_q == REFILL) && rdy && memValid && !flush && !abort_q;
        bypass       = install && fetchEn && (Addr[ADDR_BUS-1:2] == addr_q[ADDR_BUS-1:2]);
        hit          = !flush && (((state_q == IDLE) && fetchEn && lookup_hit) || bypass);
        foundInst    = bypass ? memInst : lookup_data;
        for (int w = 0; w < WAYS; w++) begin
            way_we[w] = install && (victim == PTR_W'(w));
        end
    end

    // Round-robin pointers advance only when a full set loses a line; flush
    // leaves them untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                rr_ptr_q[s] <= '0;
            end
        end else if (install && all_valid) begin
            rr_ptr_q[l_idx] <= ptr_next;
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// -----------------------------------------------------------------------------
// tb_icache_assoc
// Directed bench for icache_assoc (WAYS=2, SETS=64, TAG_W=9). Stimulus pushes
// the hand-computed expected outputs for each cycle into a scoreboard queue; a
// monitor on the falling edge pops and compares them against the DUT.
// -----------------------------------------------------------------------------
module tb_icache_assoc;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        fetchEn;
    logic [31:0] Addr;
    logic        flush;
    logic        memValid;
    logic [31:0] memInst;
    logic        hit;
    logic [31:0] foundInst;
    logic        memfetchEn;
    logic [31:0] memfetchAddr;

    always #5 clk = ~clk;

    icache_assoc #(
        .WAYS  (2),
        .SETS  (64),
        .TAG_W (9)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .fetchEn      (fetchEn),
        .Addr         (Addr),
        .flush        (flush),
        .memValid     (memValid),
        .memInst      (memInst),
        .hit          (hit),
        .foundInst    (foundInst),
        .memfetchEn   (memfetchEn),
        .memfetchAddr (memfetchAddr)
    );

    typedef struct {
        int          cyc;
        string       name;
        logic        hit;
        logic [31:0] inst;
        logic        mfe;
        bit          chk_mfa;
        logic [31:0] mfa;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.cyc != cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: expectation for cycle %0d seen at cycle %0d", mon_e.name, mon_e.cyc, cyc);
            end else begin
                check({mon_e.name, " hit"}, 32'(hit), 32'(mon_e.hit));
                if (mon_e.hit) check({mon_e.name, " foundInst"}, foundInst, mon_e.inst);
                check({mon_e.name, " memfetchEn"}, 32'(memfetchEn), 32'(mon_e.mfe));
                if (mon_e.chk_mfa) check({mon_e.name, " memfetchAddr"}, memfetchAddr, mon_e.mfa);
            end
        end
    end

    task automatic expect_out(input string name, input logic h, input logic [31:0] inst,
                              input logic mfe, input bit chk_mfa, input logic [31:0] mfa);
        exp_t e;
        e.cyc     = cyc;
        e.name    = name;
        e.hit     = h;
        e.inst    = inst;
        e.mfe     = mfe;
        e.chk_mfa = chk_mfa;
        e.mfa     = mfa;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic fe, input logic [31:0] a,
                         input logic fl, input logic mv, input logic [31:0] mi);
        rdy      = r;
        fetchEn  = fe;
        Addr     = a;
        flush    = fl;
        memValid = mv;
        memInst  = mi;
    endtask

    // Lookup with rdy=0 so that a miss does not start a refill.
    task automatic probe(input string name, input logic [31:0] a, input logic h, input logic [31:0] inst);
        drive(1'b0, 1'b1, a, 1'b0, 1'b0, 32'h0);
        expect_out(name, h, inst, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    // Full miss / request / bypass / hit sequence for one address.
    task automatic refill(input string name, input logic [31:0] a, input logic [31:0] inst);
        logic [31:0] al;
        al = {a[31:2], 2'b00};
        drive(1'b1, 1'b1, a, 1'b0, 1'b0, 32'h0);
        expect_out({name, " miss"}, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, a, 1'b0, 1'b0, 32'h0);
        expect_out({name, " req"}, 1'b0, 32'h0, 1'b1, 1'b1, al);
        tick();
        drive(1'b1, 1'b1, a, 1'b0, 1'b1, inst);
        expect_out({name, " bypass"}, 1'b1, inst, 1'b1, 1'b1, al);
        tick();
        drive(1'b1, 1'b1, a, 1'b0, 1'b0, 32'h0);
        expect_out({name, " hit"}, 1'b1, inst, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out(name, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        do_reset("reset");

        // Cold miss, same-cycle bypass, then hit in IDLE.
        probe("cold_probe", 32'h100, 1'b0, 32'h0);
        refill("cold", 32'h100, 32'h0000_0013);
        probe("cold_again", 32'h100, 1'b1, 32'h0000_0013);

        // Conflict in set 0: third fill evicts way 0 (pointer 0).
        do_reset("reset2");
        refill("c0", 32'h000, 32'hA000_0000);
        refill("c1", 32'h100, 32'hA000_0001);
        refill("c2", 32'h202, 32'hA000_0002);
        probe("c_keep", 32'h100, 1'b1, 32'hA000_0001);
        probe("c_evict", 32'h000, 1'b0, 32'h0);
        probe("c_new", 32'h200, 1'b1, 32'hA000_0002);

        // Flush invalidates everything; hit is 0 in the flush cycle.
        refill("f40", 32'h040, 32'hC000_0000);
        refill("f80", 32'h080, 32'hC000_0001);
        drive(1'b1, 1'b1, 32'h040, 1'b1, 1'b0, 32'h0);
        expect_out("flush_cycle", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        probe("fl_40", 32'h040, 1'b0, 32'h0);
        probe("fl_80", 32'h080, 1'b0, 32'h0);
        probe("fl_100", 32'h100, 1'b0, 32'h0);
        probe("fl_200", 32'h200, 1'b0, 32'h0);

        // Set 0 pointer is 1 and survives the flush: third fill evicts way 1.
        refill("p0", 32'h000, 32'hB000_0000);
        refill("p1", 32'h100, 32'hB000_0001);
        refill("p2", 32'h200, 32'hB000_0002);
        probe("p_keep", 32'h000, 1'b1, 32'hB000_0000);
        probe("p_evict", 32'h100, 1'b0, 32'h0);
        probe("p_new", 32'h200, 1'b1, 32'hB000_0002);

        // Flush mid-refill: memValid later installs nothing, no bypass.
        drive(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
        expect_out("ab miss", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'h0);
        expect_out("ab flush", 1'b0, 32'h0, 1'b1, 1'b1, 32'h300);
        tick();
        drive(1'b1, 1'b1, 32'h300, 1'b0, 1'b1, 32'hD000_0000);
        expect_out("ab memvalid", 1'b0, 32'h0, 1'b1, 1'b1, 32'h300);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("ab idle", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        probe("ab_300", 32'h300, 1'b0, 32'h0);

        // Flush and memValid together: flush wins, back to IDLE.
        drive(1'b1, 1'b1, 32'h340, 1'b0, 1'b0, 32'h0);
        expect_out("fm miss", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 32'h340, 1'b1, 1'b1, 32'hD000_0001);
        expect_out("fm both", 1'b0, 32'h0, 1'b1, 1'b1, 32'h340);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("fm idle", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        probe("fm_340", 32'h340, 1'b0, 32'h0);

        // Redirect mid-refill: no bypass, 0x400 still installed.
        drive(1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0);
        expect_out("rd miss", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 32'h800, 1'b0, 1'b0, 32'h0);
        expect_out("rd req", 1'b0, 32'h0, 1'b1, 1'b1, 32'h400);
        tick();
        drive(1'b1, 1'b1, 32'h800, 1'b0, 1'b1, 32'hE000_0000);
        expect_out("rd memvalid", 1'b0, 32'h0, 1'b1, 1'b1, 32'h400);
        tick();
        drive(1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0);
        expect_out("rd hit400", 1'b1, 32'hE000_0000, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 32'h800, 1'b0, 1'b0, 32'h0);
        expect_out("rd miss800", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("rd req800", 1'b0, 32'h0, 1'b1, 1'b1, 32'h800);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hE000_0001);
        expect_out("rd fill800", 1'b0, 32'h0, 1'b1, 1'b1, 32'h800);
        tick();
        probe("rd_800", 32'h800, 1'b1, 32'hE000_0001);
        probe("rd_400", 32'h400, 1'b1, 32'hE000_0000);

        // rdy stall across memValid: install waits for rdy.
        drive(1'b1, 1'b1, 32'hC00, 1'b0, 1'b0, 32'h0);
        expect_out("st miss", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hF000_0000);
            expect_out("st frozen", 1'b0, 32'h0, 1'b1, 1'b1, 32'hC00);
            tick();
        end
        drive(1'b1, 1'b1, 32'hC00, 1'b0, 1'b1, 32'hF000_0000);
        expect_out("st release", 1'b1, 32'hF000_0000, 1'b1, 1'b1, 32'hC00);
        tick();
        probe("st_c00", 32'hC00, 1'b1, 32'hF000_0000);
        probe("st_800", 32'h800, 1'b1, 32'hE000_0001);
        probe("st_400", 32'h400, 1'b0, 32'h0);

        // Reset during refill drops the request; later memValid is ignored.
        drive(1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
        expect_out("rr miss", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("rr req", 1'b0, 32'h0, 1'b1, 1'b1, 32'h500);
        tick();
        do_reset("rr reset");
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
        expect_out("rr late memvalid", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        probe("rr_500", 32'h500, 1'b0, 32'h0);
        probe("rr_c00", 32'hC00, 1'b0, 32'h0);

        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        check("sb_drain", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
